// File: rtl/sram_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sram_cmd_pkg
// Shared types for the AVR-side SRAM command engine: the 3-bit opcode set,
// the access sequencer states and small opcode classification helpers.
// -----------------------------------------------------------------------------
package sram_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_SHIFT     = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_READ_INC  = 3'd4,
    CMD_WRITE_INC = 3'd5,
    CMD_SNES_ON   = 3'd6,
    CMD_SNES_OFF  = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Opcodes that run a timed bus cycle.
  function automatic logic op_is_access(input cmd_op_e op);
    return (op == CMD_READ) || (op == CMD_WRITE) ||
           (op == CMD_READ_INC) || (op == CMD_WRITE_INC);
  endfunction

  function automatic logic op_is_write(input cmd_op_e op);
    return (op == CMD_WRITE) || (op == CMD_WRITE_INC);
  endfunction

  function automatic logic op_is_inc(input cmd_op_e op);
    return (op == CMD_READ_INC) || (op == CMD_WRITE_INC);
  endfunction

endpackage

// File: rtl/sram_addr_reg.sv
// -----------------------------------------------------------------------------
// sram_addr_reg
// SRAM address register. Loads serially (MSB first) from si_i and optionally
// post-increments by one, wrapping modulo 2^ADDR_WIDTH.
//
// Ports
//   clk_i       clock
//   rst_i       asynchronous active-high reset (address -> 0)
//   shift_en_i  shift si_i into the LSB
//   si_i        serial address bit
//   inc_en_i    add one to the address (ignored when INC_EN = 0)
//   addr_o      current address
//
// INC_EN = 0 leaves the incrementer out entirely.
// -----------------------------------------------------------------------------
module sram_addr_reg #(
  parameter int ADDR_WIDTH = 21,
  parameter bit INC_EN     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  shift_en_i,
  input  logic                  si_i,
  input  logic                  inc_en_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] addr_inc;

  generate
    if (INC_EN) begin : g_inc
      assign addr_inc = addr_q + ADDR_WIDTH'(1);
    end else begin : g_no_inc
      logic unused_inc_en;
      assign unused_inc_en = inc_en_i;
      assign addr_inc      = addr_q;
    end
  endgenerate

  always_comb begin
    addr_d = addr_q;
    if (shift_en_i) begin
      addr_d = {addr_q[ADDR_WIDTH-2:0], si_i};
    end else if (INC_EN && inc_en_i) begin
      addr_d = addr_inc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/sram_cmd_engine.sv
// -----------------------------------------------------------------------------
// sram_cmd_engine
// AVR-side SRAM access engine: decodes 3-bit opcodes, loads the SRAM address
// serially, runs timed read/write strobe sequences and holds the SNES/AVR
// bus-ownership flag.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   cmd, cmd_valid           opcode and strobe
//   cmd_ready                engine idle (registered)
//   cmd_err                  one-cycle pulse on an access rejected in SNES mode
//   si                       serial address bit, MSB first
//   avr_wdata                write data, captured on accept
//   avr_rdata, rdata_valid   read result and its update pulse
//   sram_addr                address register
//   sram_dout, sram_doe      data to SRAM and its drive enable
//   sram_din                 data from SRAM
//   sram_ce_n/oe_n/we_n      active-low strobes (all registered)
//   snes_mode                1 = SNES owns SRAM
//
// Build option: define SRAM_CMD_AUTOINC_EN to make READ_INC/WRITE_INC
// post-increment the address; otherwise they behave as READ/WRITE.
//
// state  | meaning
// IDLE   | ready for a command, bus released
// SETUP  | ce_n low, oe_n low (read) or doe high (write)
// STROBE | WAIT_CYCLES cycles of oe_n/we_n low, down-counter to zero
// HOLD   | strobe released, ce_n/data held one cycle, read result valid
// -----------------------------------------------------------------------------
module sram_cmd_engine
  import sram_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH  = 21,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            cmd,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  cmd_err,
  input  logic                  si,
  input  logic [DATA_WIDTH-1:0] avr_wdata,
  output logic [DATA_WIDTH-1:0] avr_rdata,
  output logic                  rdata_valid,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_doe,
  input  logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  snes_mode
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

`ifdef SRAM_CMD_AUTOINC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic                  snes_q, snes_d;
  logic                  ready_q, ready_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic                  doe_q, doe_d;
`ifdef SRAM_CMD_AUTOINC_EN
  logic                  inc_q, inc_d;
`endif

  logic    accept;
  logic    shift_en;
  logic    inc_en;
  cmd_op_e op;

  assign op     = cmd_op_e'(cmd);
  assign accept = cmd_valid && ready_q;

  sram_addr_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INC_EN     (INC_EN)
  ) u_addr_reg (
    .clk_i      (clk),
    .rst_i      (reset),
    .shift_en_i (shift_en),
    .si_i       (si),
    .inc_en_i   (inc_en),
    .addr_o     (sram_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      snes_q   <= 1'b0;
      ready_q  <= 1'b1;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      doe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      snes_q   <= snes_d;
      ready_q  <= ready_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      doe_q    <= doe_d;
    end
  end

`ifdef SRAM_CMD_AUTOINC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_q <= 1'b0;
    end else begin
      inc_q <= inc_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    snes_d   = snes_q;
    shift_en = 1'b0;
    inc_en   = 1'b0;
`ifdef SRAM_CMD_AUTOINC_EN
    inc_d    = inc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == CMD_SHIFT) begin
            shift_en = 1'b1;
          end else if (op == CMD_SNES_ON) begin
            snes_d = 1'b1;
          end else if (op == CMD_SNES_OFF) begin
            snes_d = 1'b0;
          end else if (op_is_access(op)) begin
            // In SNES mode the access is swallowed: bus untouched, error pulse.
            if (snes_q) begin
              err_d = 1'b1;
            end else begin
              state_d = ST_SETUP;
              wr_d    = op_is_write(op);
              wdata_d = avr_wdata;
`ifdef SRAM_CMD_AUTOINC_EN
              inc_d   = op_is_inc(op);
`endif
            end
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = CW'(WAIT_CYCLES - 1);
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          // Last strobe cycle: data has settled for WAIT_CYCLES cycles.
          if (!wr_q) begin
            rdata_d  = sram_din;
            rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
`ifdef SRAM_CMD_AUTOINC_EN
        inc_en  = inc_q;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus outputs are decoded from the next state and registered so that the
    // strobes are glitch-free and reset drops them asynchronously.
    ready_d = (state_d == ST_IDLE);
    ce_n_d  = (state_d == ST_IDLE);
    oe_n_d  = !(!wr_d && ((state_d == ST_SETUP) || (state_d == ST_STROBE)));
    we_n_d  = !(wr_d && (state_d == ST_STROBE));
    doe_d   = wr_d && (state_d != ST_IDLE);
  end

  assign cmd_ready   = ready_q;
  assign cmd_err     = err_q;
  assign avr_rdata   = rdata_q;
  assign rdata_valid = rvalid_q;
  assign sram_dout   = wdata_q;
  assign sram_doe    = doe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign snes_mode   = snes_q;

endmodule
